program_loader: RTL and testbench

//  Writer side of the instruction-memory interface that the pipelined processor only reads.

---
 rtl/program_loader_pkg.sv | 34 +++
 rtl/program_loader_word_assembler.sv | 56 +++++
 rtl/program_loader.sv | 150 +++++++++++++++
 tb/tb_program_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | program_loader_pkg                                                          |
// | Shared state encoding and frame constants for the instruction loader.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package program_loader_pkg;

  localparam int c_bytes_per_word = 4;
  localparam int c_byte_idx_w     = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_CHECK  = 3'd4,
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  function automatic logic state_is_busy(input state_t s);
    return (s == S_HEADER) || (s == S_DATA) || (s == S_WRITE) || (s == S_CHECK);
  endfunction

  // Byte acceptance is only offered where the frame parser consumes a byte.
  function automatic logic state_takes_bytes(input state_t s);
    return (s == S_HEADER) || (s == S_DATA) || (s == S_CHECK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
// +----------------------------------------------------------------------------+
// | program_loader_word_assembler                                               |
// | Packs bytes little-endian into a word and keeps the running XOR checksum.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module program_loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic [7:0]        i_seed,
  input  logic              i_accept,
  input  logic [7:0]        i_din,
  output logic [DATA_W-1:0] o_word_next,
  output logic [7:0]        o_csum,
  output logic              o_word_full
);

  logic [c_byte_idx_w-1:0] r_byte_idx;
  logic [DATA_W-1:0]       r_word;
  logic [7:0]              r_csum;

  // Word including the byte being accepted this cycle, so the writer can
  // launch the store on the same edge that takes the last byte.
  always_comb begin
    o_word_next = r_word;
    o_word_next[{r_byte_idx, 3'b000} +: 8] = i_din;
  end

  assign o_word_full = i_accept && (r_byte_idx == c_byte_idx_w'(c_bytes_per_word - 1));
  assign o_csum      = r_csum;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_byte_idx <= '0;
      r_word     <= '0;
      r_csum     <= '0;
    end else if (i_clear) begin
      r_byte_idx <= '0;
      r_word     <= '0;
      r_csum     <= i_seed;
    end else if (i_accept) begin
      r_byte_idx <= r_byte_idx + c_byte_idx_w'(1);
      r_word     <= o_word_next;
      r_csum     <= r_csum ^ i_din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// +----------------------------------------------------------------------------+
// | program_loader                                                              |
// | Loads a framed byte stream into instruction memory, verifies the XOR        |
// | checksum and releases the processor from reset on success.                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_wren,
  output logic [ADDR_W-1:0] im_address,
  output logic [DATA_W-1:0] im_data,
  output logic              cpu_rst,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int c_to_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_xfer;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_to_w-1:0]   r_idle;
  logic                w_timeout;
  logic                w_last_word;
  logic                w_clear;
  logic                w_accept;
  logic [DATA_W-1:0]   w_word_next;
  logic [7:0]          w_csum;
  logic                w_word_full;

  assign w_xfer      = rx_valid && rx_ready;
  assign w_clear     = (r_state == S_HEADER) && w_xfer;
  assign w_accept    = (r_state == S_DATA) && w_xfer;
  assign w_last_word = ((words_loaded + (ADDR_W+1)'(1)) == r_count);
  assign w_timeout   = (TIMEOUT != 0) && !w_xfer && (r_idle == c_to_last);

  program_loader_word_assembler #(
    .DATA_W (DATA_W)
  ) u_word_assembler (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_seed      (rx_data),
    .i_accept    (w_accept),
    .i_din       (rx_data),
    .o_word_next (w_word_next),
    .o_csum      (w_csum),
    .o_word_full (w_word_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (load_req) w_state_nxt = S_HEADER;
      S_HEADER: if (w_xfer) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_word_full)    w_state_nxt = S_WRITE;
        else if (w_timeout) w_state_nxt = S_ERROR;
      end
      S_WRITE:  w_state_nxt = w_last_word ? S_CHECK : S_DATA;
      S_CHECK: begin
        if (w_xfer)         w_state_nxt = (rx_data == w_csum) ? S_RUN : S_ERROR;
        else if (w_timeout) w_state_nxt = S_ERROR;
      end
      S_RUN:    if (load_req) w_state_nxt = S_HEADER;
      S_ERROR:  if (load_req) w_state_nxt = S_HEADER;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst    <= 1'b0;
      cpu_enable <= 1'b0;
      im_wren    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      rx_ready   <= state_takes_bytes(w_state_nxt);
      busy       <= state_is_busy(w_state_nxt);
      done       <= (w_state_nxt == S_RUN);
      err        <= (w_state_nxt == S_ERROR);
      cpu_rst    <= (w_state_nxt == S_RUN);
      cpu_enable <= (w_state_nxt == S_RUN);
      im_wren    <= (w_state_nxt == S_WRITE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      im_address   <= '0;
      im_data      <= '0;
      r_count      <= '0;
      r_addr       <= '0;
      words_loaded <= '0;
    end else begin
      if (w_word_full) begin
        im_address <= r_addr;
        im_data    <= w_word_next;
      end
      if (w_clear) begin
        r_count      <= (ADDR_W+1)'(rx_data) + (ADDR_W+1)'(1);
        r_addr       <= '0;
        words_loaded <= '0;
      end else if (r_state == S_WRITE) begin
        r_addr       <= r_addr + ADDR_W'(1);
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
      end
    end
  end

  // Idle run length only grows while the parser is waiting for a byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idle <= '0;
    end else if ((TIMEOUT != 0) && !w_xfer && (w_state_nxt == r_state) &&
                 ((r_state == S_DATA) || (r_state == S_CHECK))) begin
      r_idle <= r_idle + c_to_w'(1);
    end else begin
      r_idle <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// +----------------------------------------------------------------------------+
// | tb_program_loader                                                           |
// | Randomised frame loads compared against a frame-level model of the loader.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_program_loader;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_req = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              im_wren;
  logic [ADDR_W-1:0] im_address;
  logic [DATA_W-1:0] im_data;
  logic              cpu_rst;
  logic              cpu_enable;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  wr_t  exp_q[$];
  wr_t  log_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   inv_on   = 1'b0;
  logic prev_wren = 1'b0;

  always #5 clk = ~clk;

  program_loader #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .im_wren      (im_wren),
    .im_address   (im_address),
    .im_data      (im_data),
    .cpu_rst      (cpu_rst),
    .cpu_enable   (cpu_enable),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Every memory write must be one the model predicted, in order, and one cycle wide.
  always @(negedge clk) begin
    wr_t e;
    if (im_wren === 1'b1) begin
      chk("wren_one_cycle", {63'd0, prev_wren}, 64'd0);
      chk("wren_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {56'd0, im_address}, {56'd0, e.addr});
        chk("wr_data", {32'd0, im_data}, {32'd0, e.data});
      end
      log_q.push_back('{addr: im_address, data: im_data});
    end
    prev_wren <= im_wren;
    if (inv_on) begin
      chk("run_outputs", {62'd0, cpu_rst, cpu_enable}, {62'd0, done, done});
      chk("ready_implies_busy", {63'd0, rx_ready & ~busy}, 64'd0);
    end
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int waited;
    waited = 0;
    rx_valid = 1'b0;
    tick($urandom_range(gap_max, 0));
    rx_valid = 1'b1;
    rx_data  = b;
    forever begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 200) begin
        chk("byte_accept_timeout", 64'(waited), 64'd0);
        break;
      end
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Frame model: words are 4 data bytes little-endian at consecutive addresses
  // from 0; the check byte is the XOR of the header and every data byte.
  task automatic run_load(input logic [7:0] hdr, input bq_t data, input logic [7:0] delta,
                          input int gap_max);
    logic [7:0]  cs;
    logic [31:0] word;
    int          nw;
    nw = int'(hdr) + 1;
    cs = hdr;
    for (int w = 0; w < nw; w++) begin
      word = {data[4*w+3], data[4*w+2], data[4*w+1], data[4*w]};
      exp_q.push_back('{addr: ADDR_W'(w), data: word});
    end
    foreach (data[i]) cs = cs ^ data[i];
    log_q.delete();
    pulse_load();
    chk("load_start", {59'd0, busy, rx_ready, cpu_rst, done, err}, 64'b11000);
    send_byte(hdr, gap_max);
    foreach (data[i]) send_byte(data[i], gap_max);
    send_byte(cs ^ delta, gap_max);
    tick(2);
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    chk("load_status", {59'd0, done, cpu_rst, cpu_enable, err, busy},
        (delta == 8'h00) ? 64'b11100 : 64'b00010);
    chk("words_loaded", {55'd0, words_loaded}, 64'(nw));
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    bq_t         d;
    logic [7:0]  h;
    int          cycles;

    // Reset and idle behaviour
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {8'd0, rx_ready, im_wren, im_address, im_data, cpu_rst, cpu_enable,
                          busy, done, err, words_loaded}, 64'd0);
    rst = 1'b1;
    inv_on = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    tick(8);
    chk("idle_no_ready", {62'd0, rx_ready, busy}, 64'd0);
    rx_valid = 1'b0;

    // Two-word example frame with a good checksum
    d = '{8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h01, 8'h20};
    run_load(8'h01, d, 8'h00, 0);
    chk("ex_w0_addr", {56'd0, log_q[0].addr}, 64'h0);
    chk("ex_w0_data", {32'd0, log_q[0].data}, 64'h2000_0013);
    chk("ex_w1_addr", {56'd0, log_q[1].addr}, 64'h1);
    chk("ex_w1_data", {32'd0, log_q[1].data}, 64'h2001_0008);
    chk("ex_good", {61'd0, done, cpu_rst, words_loaded == 9'd2}, 64'b111);

    // Same frame, check byte 0x5A (correct value is 0x1B)
    run_load(8'h01, d, 8'h41, 0);
    chk("ex_bad", {61'd0, err, cpu_rst, cpu_enable}, 64'b100);
    chk("ex_bad_writes", 64'(log_q.size()), 64'd2);

    // Randomised loads with back-pressure gaps
    for (int k = 0; k < 8; k++) begin
      h = 8'($urandom_range(7, 0));
      run_load(h, rand_bytes(4 * (int'(h) + 1)),
               ($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1)), 3);
    end

    // Timeout after three data bytes
    log_q.delete();
    pulse_load();
    send_byte(8'h02, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
    cycles = 0;
    while (err !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("timeout_cycles", 64'(cycles), 64'd16);
    chk("timeout_status", {61'd0, err, busy, done}, 64'b100);
    chk("timeout_no_write", 64'(log_q.size()), 64'd0);

    // Good load, reload from RUN, then the 256-word boundary frame
    run_load(8'h00, rand_bytes(4), 8'h00, 1);
    chk("run_before_reload", {62'd0, done, cpu_rst}, 64'b11);
    run_load(8'hFF, rand_bytes(1024), 8'h00, 1);
    chk("last_addr", {56'd0, log_q[log_q.size()-1].addr}, 64'hFF);
    chk("big_words", {55'd0, words_loaded}, 64'd256);

    // Reset asserted during the WRITE cycle of the second word
    pulse_load();
    send_byte(8'h02, 0);
    d = rand_bytes(8);
    exp_q.push_back('{addr: 8'h00, data: {d[3], d[2], d[1], d[0]}});
    exp_q.push_back('{addr: 8'h01, data: {d[7], d[6], d[5], d[4]}});
    foreach (d[i]) send_byte(d[i], 0);
    chk("in_write", {63'd0, im_wren}, 64'd1);
    inv_on = 1'b0;
    rst = 1'b0;
    tick(1);
    chk("write_reset_outputs", {8'd0, rx_ready, im_wren, im_address, im_data, cpu_rst,
                                cpu_enable, busy, done, err, words_loaded}, 64'd0);
    rst = 1'b1;
    inv_on = 1'b1;
    chk("write_reset_drained", 64'(exp_q.size()), 64'd0);
    tick(20);
    chk("after_reset_idle", {62'd0, busy, im_wren}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
